mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Byte-bus bundle between the masters, the arbiter and the RAM/IO ports.
// The slave modport is the arbiter's view; the master modport is the client/memory side.
interface mem_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned RAM_ADDR_WIDTH = 17
);
  logic                        rdy_in;
  logic [NUM_MASTERS-1:0]      m_req;
  logic [NUM_MASTERS-1:0]      m_wr;
  logic [NUM_MASTERS-1:0]      m_lock;
  logic [32*NUM_MASTERS-1:0]   m_addr;
  logic [8*NUM_MASTERS-1:0]    m_dout;
  logic [NUM_MASTERS-1:0]      m_gnt;
  logic [NUM_MASTERS-1:0]      m_rvalid;
  logic [7:0]                  m_rdata;
  logic                        dbg_active;
  logic                        ram_en;
  logic                        ram_wr;
  logic [RAM_ADDR_WIDTH-1:0]   ram_a;
  logic [7:0]                  ram_din;
  logic [7:0]                  ram_dout;
  logic                        io_en;
  logic                        io_wr;
  logic [2:0]                  io_sel;
  logic [7:0]                  io_din;
  logic [7:0]                  io_dout;
  logic                        io_full;

  modport slave (
    input  rdy_in, m_req, m_wr, m_lock, m_addr, m_dout, ram_dout, io_dout, io_full,
    output m_gnt, m_rvalid, m_rdata, dbg_active,
    output ram_en, ram_wr, ram_a, ram_din, io_en, io_wr, io_sel, io_din
  );

  modport master (
    output rdy_in, m_req, m_wr, m_lock, m_addr, m_dout, ram_dout, io_dout, io_full,
    input  m_gnt, m_rvalid, m_rdata, dbg_active,
    input  ram_en, ram_wr, ram_a, ram_din, io_en, io_wr, io_sel, io_din
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Byte-bus arbiter: debug master 0 first, bus locking, 1-cycle read return.
// MEM_BUS_ARBITER_RR_EN selects round-robin (defined) or fixed priority for masters 1..N-1.
module mem_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned LOCK_MAX       = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_bus_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = 8;

  logic [NUM_MASTERS-1:0]    is_io;
  logic [NUM_MASTERS-1:0]    elig;
  logic                      win_vld;
  logic [IDX_W-1:0]          win_idx;
  logic                      lock_hit;
  logic [RAM_ADDR_WIDTH-1:0] w_a;
  logic [7:0]                w_dout;
  logic                      w_wr;
  logic                      w_io;
  logic                      w_lock;
  logic [CNT_W-1:0]          lock_cnt_n;

  logic                      lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0]          lock_own_q, lock_own_d;
  logic [CNT_W-1:0]          lock_cnt_q, lock_cnt_d;
  logic                      rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
  logic                      rd_io_q, rd_io_d;
  logic [7:0]                rdata_q, rdata_d;
`ifdef MEM_BUS_ARBITER_RR_EN
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  int unsigned               cand;
`endif

  // IO window decode and eligibility (IO writes stall while the IO sink is full)
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_elig
    assign is_io[g] = (bus.m_addr[32*g + RAM_ADDR_WIDTH -: 2] == 2'b11);
    assign elig[g]  = bus.m_req[g] && !(bus.m_wr[g] && is_io[g] && bus.io_full);
  end

  // Winner selection: eligible lock owner, then master 0, then masters 1..N-1
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    lock_hit = lock_vld_q && elig[lock_own_q];
`ifdef MEM_BUS_ARBITER_RR_EN
    cand     = 0;
`endif
    if (lock_hit) begin
      win_vld = 1'b1;
      win_idx = lock_own_q;
    end else if (elig[0]) begin
      win_vld = 1'b1;
    end else begin
`ifdef MEM_BUS_ARBITER_RR_EN
      for (int unsigned k = 0; k < NUM_MASTERS - 1; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= NUM_MASTERS) cand = cand - (NUM_MASTERS - 1);
        if (!win_vld && elig[IDX_W'(cand)]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(cand);
        end
      end
`else
      for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
        if (!win_vld && elig[IDX_W'(k)]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(k);
        end
      end
`endif
    end
    if (!bus.rdy_in || rst_in) begin
      win_vld = 1'b0;
      win_idx = '0;
    end
  end

  // Route the winner's request onto the RAM or IO port
  always_comb begin
    w_a    = '0;
    w_dout = '0;
    w_wr   = 1'b0;
    w_io   = 1'b0;
    w_lock = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        w_a    = bus.m_addr[32*i +: RAM_ADDR_WIDTH];
        w_dout = bus.m_dout[8*i +: 8];
        w_wr   = bus.m_wr[i];
        w_io   = is_io[i];
        w_lock = bus.m_lock[i];
      end
    end
    bus.m_gnt      = win_vld ? (NUM_MASTERS'(1) << win_idx) : '0;
    bus.dbg_active = win_vld && (win_idx == '0);
    bus.ram_en     = win_vld && !w_io;
    bus.io_en      = win_vld && w_io;
    bus.ram_wr     = bus.ram_en && w_wr;
    bus.io_wr      = bus.io_en && w_wr;
    bus.ram_a      = w_a;
    bus.ram_din    = w_dout;
    bus.io_sel     = w_a[2:0];
    bus.io_din     = w_dout;
    bus.m_rvalid   = rd_vld_q ? (NUM_MASTERS'(1) << rd_idx_q) : '0;
    bus.m_rdata    = rd_vld_q ? (rd_io_q ? bus.io_dout : bus.ram_dout) : rdata_q;
  end

  // Lock tracking, read-return bookkeeping and pointer update; lock state freezes while not ready
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    lock_cnt_n = lock_hit ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
    rd_vld_d   = win_vld && !w_wr;
    rd_idx_d   = win_idx;
    rd_io_d    = win_vld && !w_wr && w_io;
    rdata_d    = bus.m_rdata;
    if (bus.rdy_in) begin
      lock_vld_d = 1'b0;
      lock_own_d = '0;
      lock_cnt_d = '0;
      if (win_vld && w_lock && (32'(lock_cnt_n) < LOCK_MAX)) begin
        lock_vld_d = 1'b1;
        lock_own_d = win_idx;
        lock_cnt_d = lock_cnt_n;
      end
    end
`ifdef MEM_BUS_ARBITER_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (win_vld && (win_idx != '0)) begin
      rr_ptr_d = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? IDX_W'(1) : win_idx + IDX_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      rd_io_q    <= 1'b0;
      rdata_q    <= '0;
`ifdef MEM_BUS_ARBITER_RR_EN
      rr_ptr_q   <= IDX_W'(1);
`endif
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      rd_io_q    <= rd_io_d;
      rdata_q    <= rdata_d;
`ifdef MEM_BUS_ARBITER_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end
endmodule
